// File: rtl/stage_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : stage_fetch_queue
// Purpose  : Instruction fetch stage with a small in-order instruction queue.
//            Decouples PC generation from decode: requests go out on a
//            valid/ready channel, responses come back in order with any
//            latency, and completed instructions leave through a ready/valid
//            handshake. A redirect flushes the queue and discards the
//            responses still owed for requests issued before it.
// Ports    : clk_i / rst_ni                      clock, async active-low reset
//            branch_taken_i, new_pc_i            redirect request and target
//            imem_req_valid_o/_ready_i/_addr_o   request channel
//            imem_resp_valid_i, imem_resp_data_i in-order response channel
//            out_valid_o/_ready_i, out_pc_o,
//            out_instruction_o                   decode-side channel
// Revision : 1.0 - initial release
// ============================================================================
module stage_fetch_queue #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_PC     = '0,
  parameter int              DEPTH        = 4,
  parameter int              MAX_INFLIGHT = 2,
  parameter int              ADDR_WORD    = 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            branch_taken_i,
  input  logic [XLEN-1:0] new_pc_i,
  output logic            imem_req_valid_o,
  input  logic            imem_req_ready_i,
  output logic [XLEN-1:0] imem_req_addr_o,
  input  logic            imem_resp_valid_i,
  input  logic [XLEN-1:0] imem_resp_data_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] out_pc_o,
  output logic [XLEN-1:0] out_instruction_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int INF_W = $clog2(MAX_INFLIGHT + 1);

  // Queue storage
  logic [XLEN-1:0]  pc_q     [DEPTH];
  logic [XLEN-1:0]  pc_d     [DEPTH];
  logic [XLEN-1:0]  instr_q  [DEPTH];
  logic [XLEN-1:0]  instr_d  [DEPTH];
  logic [DEPTH-1:0] filled_q, filled_d;

  // head: oldest entry, tail: next to allocate, fill: oldest unfilled entry
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W-1:0] fill_q, fill_d;
  logic [CNT_W-1:0] alloc_q, alloc_d;
  logic [INF_W-1:0] inflight_q, inflight_d;
  logic [INF_W-1:0] drop_q, drop_d;
  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;

  logic req_fire, pop_fire;

  // Valid is gated by reset so nothing is offered while the stage is held.
  // The remaining terms can only fall through this block's own handshake,
  // so once raised the request stays up until accepted or redirected.
  assign imem_req_valid_o = rst_ni && !branch_taken_i
                          && (alloc_q < CNT_W'(DEPTH))
                          && (inflight_q < INF_W'(MAX_INFLIGHT));
  assign req_fire = imem_req_valid_o && imem_req_ready_i;

  assign out_valid_o       = filled_q[head_q];
  assign pop_fire          = out_valid_o && out_ready_i;
  assign out_pc_o          = out_valid_o ? pc_q[head_q]    : '0;
  assign out_instruction_o = out_valid_o ? instr_q[head_q] : '0;

  generate
    if (ADDR_WORD != 0) begin : g_word_addr
      assign imem_req_addr_o = {2'b00, fetch_pc_q[XLEN-1:2]};
    end else begin : g_byte_addr
      assign imem_req_addr_o = fetch_pc_q;
    end
  endgenerate

  always_comb begin
    pc_d       = pc_q;
    instr_d    = instr_q;
    filled_d   = filled_q;
    head_d     = head_q;
    tail_d     = tail_q;
    fill_d     = fill_q;
    alloc_d    = alloc_q;
    inflight_d = inflight_q;
    drop_d     = drop_q;
    fetch_pc_d = fetch_pc_q;

    if (branch_taken_i) begin
      // Every response still owed after this cycle belongs to the old path.
      // A response arriving this cycle is consumed here and discarded.
      filled_d   = '0;
      head_d     = '0;
      tail_d     = '0;
      fill_d     = '0;
      alloc_d    = '0;
      fetch_pc_d = {new_pc_i[XLEN-1:2], 2'b00};
      inflight_d = inflight_q - INF_W'(imem_resp_valid_i);
      drop_d     = inflight_q - INF_W'(imem_resp_valid_i);
    end else begin
      if (req_fire) begin
        pc_d[tail_q]     = fetch_pc_q;
        filled_d[tail_q] = 1'b0;
        tail_d           = tail_q + PTR_W'(1);
        fetch_pc_d       = fetch_pc_q + XLEN'(4);
      end
      if (imem_resp_valid_i) begin
        if (drop_q != '0) begin
          drop_d = drop_q - INF_W'(1);
        end else begin
          instr_d[fill_q]  = imem_resp_data_i;
          filled_d[fill_q] = 1'b1;
          fill_d           = fill_q + PTR_W'(1);
        end
      end
      // The popped entry is always filled, so it never collides with the
      // fill or tail slot touched above.
      if (pop_fire) begin
        filled_d[head_q] = 1'b0;
        head_d           = head_q + PTR_W'(1);
      end
      alloc_d    = alloc_q + CNT_W'(req_fire) - CNT_W'(pop_fire);
      inflight_d = inflight_q + INF_W'(req_fire) - INF_W'(imem_resp_valid_i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]    <= '0;
        instr_q[i] <= '0;
      end
      filled_q   <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      fill_q     <= '0;
      alloc_q    <= '0;
      inflight_q <= '0;
      drop_q     <= '0;
      fetch_pc_q <= RESET_PC;
    end else begin
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      filled_q   <= filled_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      fill_q     <= fill_d;
      alloc_q    <= alloc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  // A response with nothing outstanding means the memory broke the protocol.
  a_resp_has_request : assert property (
    @(posedge clk_i) disable iff (!rst_ni) imem_resp_valid_i |-> (inflight_q != '0)
  );

endmodule
`default_nettype wire

// File: doc/stage_fetch_queue.md
Name: stage_fetch_queue

Overview:
- Parametrised successor to the single-PC fetch stage: decouples PC generation from decode with an instruction queue.
- Talks to instruction memory over a valid/ready request channel and an in-order response channel of arbitrary latency (≥1 cycle).
- Redirects (branch/jump) flush the queue and discard stale in-flight responses.
- Sits between imem and the decode stage; replaces the stall input with a ready/valid handshake.

Parameters:
XLEN, 32, width of PC, addresses and instructions
RESET_PC, 32'h0, fetch address after reset
DEPTH, 4, queue entries (power of two, ≥2)
MAX_INFLIGHT, 2, max issued-but-unanswered requests (1..DEPTH)
ADDR_WORD, 1, 1: imem_req_addr = PC>>2 (word address); 0: byte address

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
branch_taken  in  1  redirect request this cycle
new_pc  in  XLEN  redirect target; bits [1:0] forced to 0
imem_req_valid  out  1  request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  XLEN  request address (per ADDR_WORD)
imem_resp_valid  in  1  response valid (in order, one per accepted request)
imem_resp_data  in  XLEN  instruction word
out_valid  out  1  head entry holds a completed instruction
out_ready  in  1  decode accepts
out_PC  out  XLEN  PC of head instruction, 0 when !out_valid
out_instruction  out  XLEN  head instruction, 0 when !out_valid

Behaviour:
- Reset (reset==0, async): fetch_pc=RESET_PC; queue empty; inflight=0; drop_cnt=0; all outputs 0; imem_req_addr reflects RESET_PC per ADDR_WORD.
- Queue entry = {pc, instr, filled}. alloc_cnt = entries allocated (filled or not), 0..DEPTH.
- Issue: imem_req_valid = !branch_taken && alloc_cnt<DEPTH && inflight<MAX_INFLIGHT. imem_req_addr = ADDR_WORD ? fetch_pc>>2 : fetch_pc.
- Request handshake (valid&&ready): allocate tail entry with pc=fetch_pc, filled=0; fetch_pc+=4 (wraps modulo 2^XLEN); inflight+1.
- Request stability: once raised, valid/addr hold until accepted; valid drops without acceptance only on redirect.
- Response: inflight-1. If drop_cnt>0: data discarded, drop_cnt-1. Otherwise data written to oldest unfilled entry, filled=1.
- Output: out_valid = head.filled. Handshake (out_valid&&out_ready) pops head next edge. Zero-bubble: with 1-cycle memory and out_ready=1, one instruction per cycle sustained when MAX_INFLIGHT≥2.
- Redirect (branch_taken=1), highest priority:
  - All entries flushed, alloc_cnt=0.
  - fetch_pc=new_pc&~3.
  - No request issued that cycle.
  - drop_cnt = inflight − imem_resp_valid. A same-cycle response is discarded regardless.
  - A same-cycle out handshake is ignored; the queue is flushed anyway.
  - Requests from the new PC start the next cycle.
- Simultaneous issue+response+pop in one cycle: all three take effect; counters net correctly.
- Full (alloc_cnt==DEPTH): no issue; pop frees a slot, and issue resumes the following cycle.
- Redirect while drop_cnt>0: drop_cnt recomputed from inflight as above; never exceeds inflight.
- Reset mid-operation: state cleared immediately; responses to pre-reset requests are the memory's responsibility (memory must be reset too).
- Response with inflight==0 is illegal; assertion in simulation.
- Latency: request handshake at cycle t with 1-cycle memory → response t+1 → out_valid at t+2.

Test Plan:
- Reset release, DEPTH=4, MAX_INFLIGHT=2, 1-cycle memory, out_ready=1 → requests 0x0,0x1,0x2… (word addr); out_PC 0x0,0x4,0x8 on consecutive cycles, first out_valid two cycles after first handshake.
- out_ready=0 held → exactly 4 requests accepted, then imem_req_valid=0; on out_ready=1 queue drains in order; issue resumes one cycle after first pop.
- 3-cycle memory, 2 in flight, branch_taken with new_pc=0x103 → 2 later responses dropped; next request addr 0x40 (word); first out_PC=0x100.
- Redirect in same cycle as response and out handshake → response discarded, drop_cnt=inflight−1, out_valid=0 next cycle, no stale PC ever presented.
- imem_req_ready=0 for 5 cycles → valid/addr stable throughout; ADDR_WORD=0 build shows byte address 0x8 for third request.
- Assert reset low mid-burst → outputs 0 immediately; after release, first request addr=RESET_PC (0x1000 in this build).
